// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_cmd_sequencer : valid/ready command front-end that issues one ALU
// operation at a time, captures the unit result and watches for timeouts.
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int In_Data_Width = 8,
   parameter int Out_Width     = 2*In_Data_Width,
   parameter int Timeout       = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_fun,
   input  logic [In_Data_Width-1:0] cmd_a,
   input  logic [In_Data_Width-1:0] cmd_b,
   output logic [In_Data_Width-1:0] A,
   output logic [In_Data_Width-1:0] B,
   output logic [1:0]               Alu_fun,
   output logic                     arith_enable,
   output logic                     logic_enable,
   output logic                     cmp_enable,
   output logic                     shift_enable,
   input  logic [Out_Width-1:0]     arith_out,
   input  logic [In_Data_Width-1:0] logic_out,
   input  logic [1:0]               cmp_out,
   input  logic [In_Data_Width-1:0] shift_out,
   input  logic                     arith_flag,
   input  logic                     logic_flag,
   input  logic                     cmp_flag,
   input  logic                     shift_flag,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [Out_Width-1:0]     res_data,
   output logic                     res_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CNT_W = (Timeout > 1) ? $clog2(Timeout) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Timeout - 1);

   state_t           state;
   logic [1:0]       unit_sel;
   logic [CNT_W-1:0] wd_cnt;
   logic [3:0]       enables;
   logic             sel_flag;
   logic [Out_Width-1:0] sel_result;

   assign cmd_ready = (state == IDLE);
   assign {shift_enable, cmp_enable, logic_enable, arith_enable} = enables;

   // Only the unit that was issued is listened to; other flags are ignored.
   always_comb begin
      sel_flag   = 1'b0;
      sel_result = '0;
      case (unit_sel)
         2'b00: begin sel_flag = arith_flag; sel_result = arith_out;             end
         2'b01: begin sel_flag = logic_flag; sel_result = Out_Width'(logic_out); end
         2'b10: begin sel_flag = cmp_flag;   sel_result = Out_Width'(cmp_out);   end
         default: begin sel_flag = shift_flag; sel_result = Out_Width'(shift_out); end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         unit_sel  <= 2'b00;
         wd_cnt    <= '0;
         enables   <= 4'b0000;
         A         <= '0;
         B         <= '0;
         Alu_fun   <= 2'b00;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  A        <= cmd_a;
                  B        <= cmd_b;
                  Alu_fun  <= cmd_fun[1:0];
                  unit_sel <= cmd_fun[3:2];
                  enables  <= 4'b0001 << cmd_fun[3:2];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               enables <= 4'b0000;
               wd_cnt  <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               // A flag on the expiry cycle still wins over the timeout.
               if (sel_flag) begin
                  res_data  <= sel_result;
                  res_err   <= 1'b0;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else if (wd_cnt == CNT_LAST) begin
                  res_data  <= '0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// tb_alu_cmd_sequencer : directed stimulus with unit stubs, scoreboard queue
// of expected results and an independent result monitor.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_fun = '0;
   logic [7:0]  cmd_a = '0, cmd_b = '0;
   logic [7:0]  A, B;
   logic [1:0]  Alu_fun;
   logic        arith_enable, logic_enable, cmp_enable, shift_enable;
   logic [15:0] arith_out = 16'hDEAD;
   logic [7:0]  logic_out = '0, shift_out = '0;
   logic [1:0]  cmp_out;
   logic        arith_flag, logic_flag = 1'b0, cmp_flag, shift_flag = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [15:0] res_data;
   logic        res_err;

   alu_cmd_sequencer #(.In_Data_Width(8), .Out_Width(16), .Timeout(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B), .Alu_fun(Alu_fun),
      .arith_enable(arith_enable), .logic_enable(logic_enable),
      .cmp_enable(cmp_enable), .shift_enable(shift_enable),
      .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
      .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- unit stubs ----------------
   logic [15:0] arith_val = 16'h0000;
   logic        arith_flag_r = 1'b0;
   logic        arith_force = 1'b0;
   logic        logic_on = 1'b1;
   logic [1:0]  cmp_val = 2'b10;
   logic [3:0]  cpipe = '0;
   int          cmp_sel = 0;

   assign arith_flag = arith_flag_r | arith_force;
   assign cmp_flag   = cpipe[cmp_sel];
   assign cmp_out    = cmp_val;

   always @(posedge clk) begin
      arith_flag_r <= arith_enable;
      if (arith_enable) arith_out <= arith_val;
      logic_flag <= logic_enable & logic_on;
      if (logic_enable)
         case (Alu_fun)
            2'b00: logic_out <= A & B;
            2'b01: logic_out <= A | B;
            2'b10: logic_out <= A ^ B;
            default: logic_out <= ~(A & B);
         endcase
      shift_flag <= shift_enable;
      if (shift_enable)
         case (Alu_fun)
            2'b00: shift_out <= A >> 1;
            2'b01: shift_out <= B << 1;
            2'b10: shift_out <= A << 1;
            default: shift_out <= B >> 1;
         endcase
      cpipe <= {cpipe[2:0], cmp_enable};
   end

   // ---------------- checking ----------------
   typedef struct {
      logic [15:0] d;
      logic        e;
      int          lat;
   } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   int          acc_cyc = 0;
   logic        prev_v = 1'b0;
   logic [16:0] held = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (res_valid && !prev_v) begin
               if (sbq.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  exp_t e;
                  e = sbq.pop_front();
                  check("res_data", res_data, e.d);
                  check("res_err", res_err, e.e);
                  check("latency", cyc - acc_cyc, e.lat);
               end
            end else if (res_valid && prev_v) begin
               check("res_hold", {res_err, res_data}, held);
            end
            prev_v = res_valid;
            held   = {res_err, res_data};
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ed, input logic ee, input int el,
                        input bit push, output int acc);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_fun = fun; cmd_a = a; cmd_b = b;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) got = 1'b1;
      end
      check("accept", got, 1);
      acc = cyc;
      if (got) begin
         if (push) sbq.push_back('{ed, ee, el});
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         @(negedge clk);
         check("issue_enable", {shift_enable, cmp_enable, logic_enable, arith_enable},
               4'b0001 << fun[3:2]);
         check("alu_fun", Alu_fun, fun[1:0]);
         check("operands", {A, B}, {a, b});
         @(negedge clk);
         check("enable_drop", {shift_enable, cmp_enable, logic_enable, arith_enable}, 0);
      end else begin
         cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready && !res_valid) got = 1'b1;
      end
      check("reach_idle", got, 1);
   endtask

   task automatic check_reset_outputs(input string nm);
      check(nm, {A, B, Alu_fun, arith_enable, logic_enable, cmp_enable, shift_enable,
                 res_valid, res_err, res_data}, 0);
      check({nm, "_ready"}, cmd_ready, 1);
   endtask

   int acc;
   int accs[4];
   logic [15:0] b2b_vals[4] = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFF38};

   initial begin
      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_values");
      rst = 1'b0;

      // shift unit: B<<1 of 8'h41 = 8'h82, zero-extended
      issue(4'b1101, 8'h12, 8'h41, 16'h0082, 1'b0, 3, 1'b1, acc);
      wait_idle();

      // backpressure: result held 5 cycles while another command waits upstream
      res_ready = 1'b0;
      issue(4'b1100, 8'h12, 8'h41, 16'h0009, 1'b0, 3, 1'b1, acc);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_fun = 4'b0100; cmd_a = 8'hF0; cmd_b = 8'h3C;
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
         end
         check("bp_res_valid", seen, 1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_no_enable", {shift_enable, cmp_enable, logic_enable, arith_enable}, 0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      issue(4'b0100, 8'hF0, 8'h3C, 16'h0030, 1'b0, 3, 1'b1, acc);
      wait_idle();

      // timeout: logic unit silent
      logic_on = 1'b0;
      issue(4'b0110, 8'h55, 8'hAA, 16'h0000, 1'b1, 6, 1'b1, acc);
      wait_idle();

      // foreign arith flag held high during a slow cmp command
      arith_force = 1'b1;
      cmp_sel = 2; cmp_val = 2'b10;
      issue(4'b1000, 8'h05, 8'h03, 16'h0002, 1'b0, 5, 1'b1, acc);
      wait_idle();
      arith_force = 1'b0;

      // cmp flag on the watchdog expiry cycle: result wins
      cmp_sel = 3; cmp_val = 2'b01;
      issue(4'b1001, 8'h01, 8'h02, 16'h0001, 1'b0, 6, 1'b1, acc);
      wait_idle();
      cmp_sel = 0;

      // asynchronous reset in WAIT aborts the command
      issue(4'b0101, 8'h0F, 8'hF0, 16'h0000, 1'b0, 0, 1'b0, acc);
      rst = 1'b1;
      #1;
      check_reset_outputs("midwait_reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      logic_on = 1'b1;

      // arith full-width result after reset
      arith_val = 16'hFF38;
      issue(4'b0010, 8'hF6, 8'h14, 16'hFF38, 1'b0, 3, 1'b1, acc);
      wait_idle();

      // four back-to-back commands, one every 4 cycles
      for (int i = 0; i < 4; i++) begin
         arith_val = b2b_vals[i];
         issue(4'(i), 8'(i), 8'h10, b2b_vals[i], 1'b0, 3, 1'b1, accs[i]);
      end
      for (int i = 1; i < 4; i++) check("b2b_spacing", accs[i] - accs[i-1], 4);
      wait_idle();

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
